// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - instruction queue between fetch and decode
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             flush_i,
    input  logic             jal_redirect_i,
    input  logic             fetch_valid_i,
    input  logic [63:0]      fetch_pc_i,
    input  logic [31:0]      fetch_inst_i,
    input  logic             fetch_bpred_taken_i,
    input  logic [63:0]      fetch_bpred_target_i,
    input  logic             fetch_ex_valid_i,
    input  logic [63:0]      fetch_ex_cause_i,
    input  logic [63:0]      fetch_ex_origin_i,
    output logic             ready_o,
    input  logic             deq_i,
    output logic             valid_o,
    output logic [63:0]      pc_o,
    output logic [31:0]      inst_o,
    output logic             bpred_taken_o,
    output logic [63:0]      bpred_target_o,
    output logic             ex_valid_o,
    output logic [63:0]      ex_cause_o,
    output logic [63:0]      ex_origin_o,
    output logic [PTR_W:0]   count_o
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        bpred_taken;
        logic [63:0] bpred_target;
        logic        ex_valid;
        logic [63:0] ex_cause;
        logic [63:0] ex_origin;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             enq;
    logic             deq;
    logic             redirect;
    logic             accept_enq;
    entry_t           head;
    entry_t           wr_entry;

    // Handshake decode; ready depends only on the registered count, never on deq_i
    always_comb begin
        valid_o    = (count != '0);
        ready_o    = (count != FULL_COUNT);
        enq        = fetch_valid_i & ready_o;
        deq        = deq_i & valid_o;
        redirect   = jal_redirect_i & deq;
        accept_enq = enq & ~flush_i & ~redirect;
        head       = mem[rd_ptr];
        wr_entry   = '{pc:           fetch_pc_i,
                       inst:         fetch_inst_i,
                       bpred_taken:  fetch_bpred_taken_i,
                       bpred_target: fetch_bpred_target_i,
                       ex_valid:     fetch_ex_valid_i,
                       ex_cause:     fetch_ex_cause_i,
                       ex_origin:    fetch_ex_origin_i};
    end

    assign pc_o           = head.pc;
    assign inst_o         = head.inst;
    assign bpred_taken_o  = head.bpred_taken;
    assign bpred_target_o = head.bpred_target;
    assign ex_valid_o     = head.ex_valid;
    assign ex_cause_o     = head.ex_cause;
    assign ex_origin_o    = head.ex_origin;
    assign count_o        = count;

    // Pointer and occupancy update: flush beats JAL redirect beats normal traffic
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Head is consumed; everything younger, including this cycle's fetch, is wrong-path
            rd_ptr <= rd_ptr + PTR_ONE;
            wr_ptr <= rd_ptr + PTR_ONE;
            count  <= '0;
        end else begin
            if (accept_enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept_enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; flushes only move pointers, contents stay until overwritten
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept_enq) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Decoupling instruction queue between the fetch stage and the decoder.
- Buffers up to DEPTH fetched instructions with their PC, branch prediction and fetch-exception info, and presents the oldest one to decode with a valid/accept handshake.
- Absorbs decode stalls without stalling fetch until full.
- Discards wrong-path entries on a backend flush or a decode-resolved JAL redirect.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk_i  in  1  core clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  backend flush; empties the queue
jal_redirect_i  in  1  decoder resolved a JAL on the head entry; younger entries are wrong-path
fetch_valid_i  in  1  fetch presents an instruction this cycle
fetch_pc_i  in  64  instruction PC
fetch_inst_i  in  32  instruction word
fetch_bpred_taken_i  in  1  predictor decision
fetch_bpred_target_i  in  64  predicted target
fetch_ex_valid_i  in  1  fetch-side exception (e.g. access fault)
fetch_ex_cause_i  in  64  exception cause
fetch_ex_origin_i  in  64  faulting address
ready_o  in fetch direction  out  1  queue can accept this cycle
deq_i  in  1  decoder consumes head this cycle
valid_o  out  1  head entry valid
pc_o  out  64  head PC
inst_o  out  32  head instruction
bpred_taken_o  out  1  head prediction
bpred_target_o  out  64  head target
ex_valid_o  out  1  head exception flag
ex_cause_o  out  64  head cause
ex_origin_o  out  64  head origin
count_o  out  PTR_W+1  current occupancy (debug/perf)

Behaviour:
- Reset (rstn_i low, asynchronous): read and write pointers = 0, count = 0, every storage field = 0. valid_o=0, ready_o=1, count_o=0, all payload outputs 0.
- Storage: DEPTH-entry circular buffer with PTR_W-bit pointers that wrap naturally from DEPTH-1 to 0. Count is tracked separately, so full and empty are unambiguous.
- ready_o = (count != DEPTH). Combinational from registered count only; no dependence on deq_i, so a full queue does not accept in the same cycle it is drained.
- enq = fetch_valid_i & ready_o. Writes all fetch fields at the write pointer; the write pointer increments at the next edge.
- deq = deq_i & valid_o. The read pointer increments. deq_i while empty is ignored.
- valid_o = (count != 0). Payload outputs are the entry at the read pointer, driven combinationally from storage.
- Latency: no bypass. An instruction enqueued at edge N is visible on valid_o after edge N, i.e. one cycle minimum fetch-to-decode.
- Simultaneous enq and deq when 0 < count < DEPTH: count unchanged, both pointers advance.
- Priority at each edge:
  1. flush_i: pointers and count to 0. Any same-cycle enq and deq are discarded. Storage contents are not cleared.
  2. jal_redirect_i & deq: head is consumed, all remaining entries are dropped, and any same-cycle enq is discarded (wrong path). Write pointer = read pointer + 1, count = 0.
  3. Otherwise normal enq/deq.
- jal_redirect_i without deq (head not accepted, or queue empty) is ignored.
- flush_i and jal_redirect_i together: flush rules.
- An exception entry travels like any other; the queue never interprets inst or ex fields.
- count_o never exceeds DEPTH. Overflow is impossible by construction; an assertion in the bench checks count <= DEPTH.

Test Plan:
- Reset then idle: after rstn_i deassert, valid_o=0, ready_o=1, count_o=0; deq_i=1 for 3 cycles leaves count_o=0.
- Fill under stall: deq_i=0, push PC 0x1000 then 0x1004 → count_o=2, ready_o=0. A third push of 0x1008 is dropped. Then deq_i=1 for 2 cycles → pc_o=0x1000 then 0x1004, valid_o=0 afterwards.
- Streaming with wrap: deq_i=1 and fetch_valid_i=1 continuously with PCs 0x2000+4k for 10 cycles → pc_o sequence matches in order, one-cycle lag, count_o stays 1, pointers wrap at least 4 times.
- Flush mid-traffic: queue holds 0x3000 and 0x3004, and push 0x3008 with flush_i=1 in the same cycle → next cycle valid_o=0, count_o=0. A following push of 0x4000 appears alone.
- JAL redirect: queue holds 0x5000 (JAL) and 0x5004, push 0x5008, deq_i=1 and jal_redirect_i=1 → next cycle count_o=0. Next push 0x6000 appears at head. Separately, jal_redirect_i=1 with deq_i=0 → queue contents unchanged.
- Exception passthrough and async reset: push ex_valid=1, cause=0x1, origin=0xDEAD0000 → outputs match. Asserting rstn_i low mid-cycle with count=2 → valid_o drops to 0 immediately, without waiting for a clock edge.
